zc_sample_sched: RTL and testbench

//  Input-side scheduler for the zero-crossing soft-processor wrapper.
//  - Buffers two ADC sample streams in per-channel FIFOs.
//  - Serves the processor's one-hot req_in reads from those FIFOs.
//  - Raises a one-cycle itr pulse once a full frame is ready on both channels.
//  - Sequences frames IDLE->IRQ->RUN and waits for proc_done before arming again.

---
 rtl/zc_sample_sched.sv | 179 +++++++++++++++++
 tb/tb_zc_sample_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zc_sample_sched.sv
// zc_sample_sched: input-side scheduler for the zero-crossing soft processor.
// Buffers two signed ADC sample streams in per-channel FIFOs, serves one-hot
// processor reads from the FIFO heads, and sequences frames IDLE->IRQ->RUN.
// The processor is interrupted once both channels hold a full frame.
// Optional build macro: ZC_WDOG_EN adds a RUN-state watchdog that forces the
// sequencer back to IDLE after WDOG cycles without proc_done.
module zc_sample_sched #(
  parameter int DW    = 23,
  parameter int AW    = 4,
  parameter int FRAME = 8,
  parameter int WDOG  = 4096
) (
  input  logic                 clk,
  input  logic                 rst_geral,
  input  logic signed [DW-1:0] adc0_data,
  input  logic                 adc0_vld,
  input  logic signed [DW-1:0] adc1_data,
  input  logic                 adc1_vld,
  input  logic [1:0]           req_in,
  input  logic                 proc_done,
  output logic signed [DW-1:0] in_proc,
  output logic                 itr,
  output logic                 busy,
  output logic [AW:0]          lvl0,
  output logic [AW:0]          lvl1,
  output logic [1:0]           ovf,
  output logic [1:0]           unf,
  output logic                 wdog_to
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0] FRAME_L = (AW+1)'(FRAME);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IRQ  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  // Per-channel storage and bookkeeping, indexed by channel number.
  logic signed [DW-1:0] mem [2][DEPTH];
  logic [AW-1:0]        wr_ptr [2];
  logic [AW-1:0]        rd_ptr [2];
  logic [AW:0]          lvl    [2];
  logic signed [DW-1:0] din    [2];
  logic [1:0]           vld;
  logic [1:0]           sel;
  logic [1:0]           empty;
  logic [1:0]           full;
  logic [1:0]           push;
  logic [1:0]           pop;

  logic [1:0] state;
  logic       frame_rdy;
  logic       wdog_hit;

  // Decode the read request and decide which pushes and pops happen this cycle.
  always_comb begin
    din[0] = adc0_data;
    din[1] = adc1_data;
    vld    = {adc1_vld, adc0_vld};
    // 11 is an illegal request and is treated like 00: no channel selected.
    sel    = 2'b00;
    if (req_in == 2'b01) sel = 2'b01;
    if (req_in == 2'b10) sel = 2'b10;
    empty  = 2'b00;
    full   = 2'b00;
    pop    = 2'b00;
    push   = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      empty[ch] = (lvl[ch] == '0);
      full[ch]  = (lvl[ch] == FULL_L);
      pop[ch]   = sel[ch] & ~empty[ch];
      // A full FIFO still accepts a push when its head leaves in the same cycle.
      push[ch]  = vld[ch] & (~full[ch] | pop[ch]);
    end
  end

  // Present the selected FIFO head to the processor; empty or no request reads 0.
  always_comb begin
    in_proc = '0;
    if (pop[0]) in_proc = mem[0][rd_ptr[0]];
    if (pop[1]) in_proc = mem[1][rd_ptr[1]];
  end

  // Sample storage: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (push[ch]) mem[ch][wr_ptr[ch]] <= din[ch];
    end
  end

  // FIFO pointers, occupancy and sticky overflow/underflow flags.
  always_ff @(posedge clk) begin
    if (rst_geral) begin
      for (int ch = 0; ch < 2; ch++) begin
        wr_ptr[ch] <= '0;
        rd_ptr[ch] <= '0;
        lvl[ch]    <= '0;
      end
      ovf <= 2'b00;
      unf <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        // Pointers are AW bits wide, so they wrap modulo the depth naturally.
        if (push[ch]) wr_ptr[ch] <= wr_ptr[ch] + AW'(1);
        if (pop[ch])  rd_ptr[ch] <= rd_ptr[ch] + AW'(1);
        case ({push[ch], pop[ch]})
          2'b10:   lvl[ch] <= lvl[ch] + (AW+1)'(1);
          2'b01:   lvl[ch] <= lvl[ch] - (AW+1)'(1);
          default: lvl[ch] <= lvl[ch];
        endcase
        if (vld[ch] && full[ch] && !pop[ch]) ovf[ch] <= 1'b1;
        if (sel[ch] && empty[ch])            unf[ch] <= 1'b1;
      end
    end
  end

  assign lvl0 = lvl[0];
  assign lvl1 = lvl[1];

  assign frame_rdy = (lvl[0] >= FRAME_L) && (lvl[1] >= FRAME_L);
  assign busy      = (state != S_IDLE);

  // Frame sequencer; itr is registered together with the IDLE->IRQ transition.
  always_ff @(posedge clk) begin
    if (rst_geral) begin
      state <= S_IDLE;
      itr   <= 1'b0;
    end else begin
      itr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_rdy) begin
            state <= S_IRQ;
            itr   <= 1'b1;
          end
        end
        S_IRQ: begin
          state <= S_RUN;
        end
        S_RUN: begin
          // proc_done wins over a simultaneous watchdog expiry.
          if (proc_done || wdog_hit) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ZC_WDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(WDOG - 1);

  logic [31:0] wdog_cnt;

  // The count equals (RUN cycle number - 1); expiry lands on RUN cycle WDOG.
  assign wdog_hit = (state == S_RUN) && (wdog_cnt == WDOG_LAST) && !proc_done;

  // RUN-state watchdog counter and its sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst_geral) begin
      wdog_cnt <= '0;
      wdog_to  <= 1'b0;
    end else begin
      if (state == S_IRQ)      wdog_cnt <= '0;
      else if (state == S_RUN) wdog_cnt <= wdog_cnt + 32'd1;
      if (wdog_hit) wdog_to <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign wdog_hit   = 1'b0;
  assign wdog_to    = 1'b0;
  assign unused_cfg = ^WDOG;
`endif

endmodule

// File: tb/tb_zc_sample_sched.sv
// Bench for zc_sample_sched: table vectors, directed frame/overflow/reset
// sequences and a randomized phase, all checked against a queue-based model.
module tb_zc_sample_sched;

  localparam int DW    = 23;
  localparam int AW    = 4;
  localparam int FRAME = 8;
  localparam int DEPTH = 16;
`ifdef ZC_WDOG_EN
  localparam int WDOG  = 100;
`else
  localparam int WDOG  = 4096;
`endif

  logic                 clk;
  logic                 rst_geral;
  logic signed [DW-1:0] adc0_data;
  logic                 adc0_vld;
  logic signed [DW-1:0] adc1_data;
  logic                 adc1_vld;
  logic [1:0]           req_in;
  logic                 proc_done;
  logic signed [DW-1:0] in_proc;
  logic                 itr;
  logic                 busy;
  logic [AW:0]          lvl0;
  logic [AW:0]          lvl1;
  logic [1:0]           ovf;
  logic [1:0]           unf;
  logic                 wdog_to;

  zc_sample_sched #(.DW(DW), .AW(AW), .FRAME(FRAME), .WDOG(WDOG)) dut (
    .clk(clk), .rst_geral(rst_geral),
    .adc0_data(adc0_data), .adc0_vld(adc0_vld),
    .adc1_data(adc1_data), .adc1_vld(adc1_vld),
    .req_in(req_in), .proc_done(proc_done),
    .in_proc(in_proc), .itr(itr), .busy(busy),
    .lvl0(lvl0), .lvl1(lvl1), .ovf(ovf), .unf(unf), .wdog_to(wdog_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec;
  int nerr;
  int obs_in;

  // Reference model: queues for the FIFOs plus frame bookkeeping.
  int   q0[$];
  int   q1[$];
  logic [1:0] m_ovf;
  logic [1:0] m_unf;
  bit   m_itr;
  bit   m_busy;
  bit   m_irq;
  bit   m_wdog;
  int   m_rc;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_ovf = 2'b00; m_unf = 2'b00;
    m_itr = 0; m_busy = 0; m_irq = 0; m_wdog = 0; m_rc = 0;
  endtask

  function automatic int model_head(input logic [1:0] rq);
    if (rq == 2'b01 && q0.size() > 0) return q0[0];
    if (rq == 2'b10 && q1.size() > 0) return q1[0];
    return 0;
  endfunction

  task automatic model_step(input bit v0, input int d0, input bit v1, input int d1,
                            input logic [1:0] rq, input bit dn);
    bit p0, p1, frame;
    p0 = (rq == 2'b01) && (q0.size() > 0);
    p1 = (rq == 2'b10) && (q1.size() > 0);
    if (rq == 2'b01 && q0.size() == 0) m_unf[0] = 1'b1;
    if (rq == 2'b10 && q1.size() == 0) m_unf[1] = 1'b1;
    frame = !m_busy && (q0.size() >= FRAME) && (q1.size() >= FRAME);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (v0) begin
      if (q0.size() < DEPTH) q0.push_back(d0); else m_ovf[0] = 1'b1;
    end
    if (v1) begin
      if (q1.size() < DEPTH) q1.push_back(d1); else m_ovf[1] = 1'b1;
    end
    m_itr = 0;
    if (!m_busy) begin
      if (frame) begin m_itr = 1; m_busy = 1; m_irq = 1; end
    end else if (m_irq) begin
      m_irq = 0;
      m_rc  = 0;
    end else begin
      m_rc++;
      if (dn) m_busy = 0;
`ifdef ZC_WDOG_EN
      else if (m_rc >= WDOG) begin m_busy = 0; m_wdog = 1; end
`endif
    end
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic cycle(input bit v0, input int d0, input bit v1, input int d1,
                       input logic [1:0] rq, input bit dn);
    adc0_vld = v0; adc0_data = DW'(d0);
    adc1_vld = v1; adc1_data = DW'(d1);
    req_in = rq; proc_done = dn;
    #2;
    obs_in = int'(in_proc);
    chk("in_proc", obs_in, model_head(rq));
    @(posedge clk);
    model_step(v0, d0, v1, d1, rq, dn);
    #1;
    chk("lvl0", int'(lvl0), q0.size());
    chk("lvl1", int'(lvl1), q1.size());
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("unf", int'(unf), int'(m_unf));
    chk("itr", int'(itr), int'(m_itr));
    chk("busy", int'(busy), int'(m_busy));
    chk("wdog_to", int'(wdog_to), int'(m_wdog));
  endtask

  task automatic do_reset();
    rst_geral = 1'b1;
    adc0_vld = 0; adc1_vld = 0; adc0_data = '0; adc1_data = '0;
    req_in = 2'b00; proc_done = 0;
    @(posedge clk);
    #1;
    rst_geral = 1'b0;
    model_reset();
    chk("rst_lvl0", int'(lvl0), 0);
    chk("rst_lvl1", int'(lvl1), 0);
    chk("rst_itr", int'(itr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_unf", int'(unf), 0);
    chk("rst_wdog_to", int'(wdog_to), 0);
    chk("rst_in_proc", int'(in_proc), 0);
  endtask

  typedef struct {
    bit v0; int d0; bit v1; int d1; logic [1:0] rq;
    int e_in; int e_l0; int e_l1; int e_unf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    nvec = 0;
    nerr = 0;
    tbl[0] = '{1, 5, 0, 0,  2'b00, 0,  1, 0, 0};
    tbl[1] = '{0, 0, 1, -3, 2'b01, 5,  0, 1, 0};
    tbl[2] = '{0, 0, 0, 0,  2'b10, -3, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0,  2'b10, 0,  0, 0, 2};
    tbl[4] = '{1, 7, 0, 0,  2'b11, 0,  1, 0, 2};
    tbl[5] = '{0, 0, 0, 0,  2'b11, 0,  1, 0, 2};
    tbl[6] = '{1, 9, 0, 0,  2'b01, 7,  1, 0, 2};
    tbl[7] = '{0, 0, 0, 0,  2'b01, 9,  0, 0, 2};
    tbl[8] = '{1, 4, 0, 0,  2'b01, 0,  1, 0, 3};

    do_reset();
    do_reset();

    // Table vectors: basic push/pop, empty reads, illegal request.
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].rq, 1'b0);
      chk($sformatf("tbl%0d_in", i), obs_in, tbl[i].e_in);
      chk($sformatf("tbl%0d_lvl0", i), int'(lvl0), tbl[i].e_l0);
      chk($sformatf("tbl%0d_lvl1", i), int'(lvl1), tbl[i].e_l1);
      chk($sformatf("tbl%0d_unf", i), int'(unf), tbl[i].e_unf);
    end

    // Full frame on both channels, then processor reads it back.
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1, i, 0, 0, 2'b00, 0);
    for (int i = 1; i <= 8; i++) cycle(0, 0, 1, -i, 2'b00, 0);
    chk("frame_itr_early", int'(itr), 0);
    cycle(0, 0, 0, 0, 2'b00, 0);
    chk("frame_itr", int'(itr), 1);
    chk("frame_busy", int'(busy), 1);
    cycle(0, 0, 0, 0, 2'b00, 0);
    chk("frame_itr_once", int'(itr), 0);
    chk("frame_busy_run", int'(busy), 1);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, 0, 2'b01, 0);
      chk("read_ch0", obs_in, i);
    end
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, 0, 2'b10, 0);
      chk("read_ch1", obs_in, -i);
    end
    chk("drain_lvl0", int'(lvl0), 0);
    chk("drain_lvl1", int'(lvl1), 0);
    chk("drain_busy", int'(busy), 1);
    cycle(0, 0, 0, 0, 2'b00, 1);
    chk("done_busy", int'(busy), 0);

    // Overflow: 17 pushes into a 16-deep FIFO, then push+pop while full.
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1, 100 + i, 0, 0, 2'b00, 0);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_lvl0", int'(lvl0), 16);
    cycle(1, 200, 0, 0, 2'b01, 0);
    chk("full_pp_head", obs_in, 100);
    chk("full_pp_lvl0", int'(lvl0), 16);
    for (int i = 1; i < 16; i++) begin
      cycle(0, 0, 0, 0, 2'b01, 0);
      chk("ovf_read", obs_in, 100 + i);
    end
    cycle(0, 0, 0, 0, 2'b01, 0);
    chk("ovf_kept", obs_in, 200);
    chk("ovf_empty", int'(lvl0), 0);

    // Reset in RUN with five samples left on channel 0.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, i + 1, 1, -(i + 1), 2'b00, 0);
    cycle(0, 0, 0, 0, 2'b00, 0);
    cycle(0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 2'b01, 0);
    chk("pre_rst_lvl0", int'(lvl0), 5);
    chk("pre_rst_busy", int'(busy), 1);
    do_reset();
    cycle(0, 0, 0, 0, 2'b01, 0);
    chk("post_rst_read", obs_in, 0);
    chk("post_rst_unf", int'(unf), 1);

`ifdef ZC_WDOG_EN
    // Watchdog: frame ready, processor never finishes.
    begin
      bit seen;
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, i, 1, i, 2'b00, 0);
      cycle(0, 0, 0, 0, 2'b00, 0);
      for (int i = 0; i < WDOG + 10 && !wdog_to; i++) cycle(0, 0, 0, 0, 2'b00, 0);
      chk("wdog_to", int'(wdog_to), 1);
      chk("wdog_idle", int'(busy), 0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        cycle(0, 0, 0, 0, 2'b00, 0);
        if (itr) seen = 1;
      end
      chk("wdog_refire", int'(seen), 1);
    end
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] rq;
      int r;
      r = int'($urandom_range(0, 5));
      case (r)
        0: rq = 2'b00;
        1, 2: rq = 2'b01;
        3, 4: rq = 2'b10;
        default: rq = 2'b11;
      endcase
      cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 4194303)) - 2097152,
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 4194303)) - 2097152,
            rq, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
